// File: rtl/piso4_8_pkg.sv
// Shared constants and FSM state type for the piso4_8 parallel-in/serial-out block.
package piso_pkg;

    localparam int WIDTH_DEF   = 8;
    localparam int NUM_REG_DEF = 4;

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

endpackage

// File: rtl/piso4_8_if.sv
// Load/stream handshake bundle for piso4_8; out_last exists only when PISO_LAST_EN is defined.
interface piso4_8_if #(
    parameter int WIDTH   = piso_pkg::WIDTH_DEF,
    parameter int NUM_REG = piso_pkg::NUM_REG_DEF
);

    logic [WIDTH*NUM_REG-1:0] A;
    logic                     in_valid;
    logic                     in_ready;
    logic [WIDTH-1:0]         B;
    logic                     out_valid;
    logic                     out_ready;
`ifdef PISO_LAST_EN
    logic                     out_last;
`endif

    modport master (
        output A, in_valid, out_ready,
        input  in_ready, B, out_valid
`ifdef PISO_LAST_EN
        , input out_last
`endif
    );

    modport slave (
        input  A, in_valid, out_ready,
        output in_ready, B, out_valid
`ifdef PISO_LAST_EN
        , output out_last
`endif
    );

endinterface

// File: rtl/piso4_8.sv
// Parallel-in/serial-out converter: loads NUM_REG words of WIDTH bits, emits element 0 first.
// Optional out_last flag is built only when PISO_LAST_EN is defined.
module piso4_8
    import piso_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int NUM_REG = NUM_REG_DEF
) (
    input  logic     clk,
    input  logic     reset,
    piso4_8_if.slave bus
);

    localparam int            CW   = (NUM_REG > 1) ? $clog2(NUM_REG) : 1;
    localparam logic [CW-1:0] LAST = CW'(NUM_REG - 1);

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_d [NUM_REG];

    logic w_shift;
    logic w_at_last;
    logic w_load;

    assign w_shift   = (r_state == SHIFT);
    assign w_at_last = (r_cnt == LAST);

    // Accepting on the final element's handshake lets the next word follow with no bubble.
    assign bus.in_ready  = !w_shift || (w_at_last && bus.out_ready);
    assign w_load        = bus.in_valid && bus.in_ready;
    assign bus.out_valid = w_shift;
    assign bus.B         = r_d[r_cnt];

`ifdef PISO_LAST_EN
    assign bus.out_last = w_shift && w_at_last;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            for (int unsigned k = 0; k < NUM_REG; k++) begin
                r_d[k] <= '0;
            end
        end else if (w_load) begin
            for (int unsigned k = 0; k < NUM_REG; k++) begin
                r_d[k] <= bus.A[k*WIDTH +: WIDTH];
            end
            r_cnt   <= '0;
            r_state <= SHIFT;
        end else if (w_shift && bus.out_ready) begin
            if (!w_at_last) begin
                r_cnt <= r_cnt + 1'b1;
            end else begin
                r_state <= IDLE;
            end
        end
    end

endmodule

// File: tb/tb_piso4_8.sv
// Self-checking bench for piso4_8: directed vector table, reset sequence, and randomized run
// against a queue-based reference model of the element stream.
module tb_piso4_8;

    localparam int W = 8;
    localparam int N = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    piso4_8_if #(.WIDTH(W), .NUM_REG(N)) bus ();

    piso4_8 #(.WIDTH(W), .NUM_REG(N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: elements still to be emitted from the current word.
    logic [W-1:0] q[$];
    bit           fresh;

    typedef struct {
        logic          iv;
        logic [31:0]   a;
        logic          ordy;
        logic          ev;
        logic          chkb;
        logic [7:0]    eb;
        logic          erdy;
        logic          elast;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic iv, input logic [31:0] a, input logic ordy, input logic ev,
                       input logic chkb, input logic [7:0] eb, input logic erdy, input logic elast);
        vec_t v;
        v.iv = iv; v.a = a; v.ordy = ordy; v.ev = ev;
        v.chkb = chkb; v.eb = eb; v.erdy = erdy; v.elast = elast;
        tbl.push_back(v);
    endtask

    task automatic drive(input logic rst, input logic [31:0] a, input logic iv, input logic ordy);
        @(negedge clk);
        reset         = rst;
        bus.A         = a;
        bus.in_valid  = iv;
        bus.out_ready = ordy;
        #1;
    endtask

    task automatic model_check();
        logic exp_rdy;
        exp_rdy = (q.size() == 0) || (q.size() == 1 && bus.out_ready);
        check("model_out_valid", {31'd0, bus.out_valid}, {31'd0, q.size() > 0});
        check("model_in_ready", {31'd0, bus.in_ready}, {31'd0, exp_rdy});
        if (q.size() > 0)
            check("model_B", {24'd0, bus.B}, {24'd0, q[0]});
        else if (fresh)
            check("model_B_reset", {24'd0, bus.B}, 32'd0);
`ifdef PISO_LAST_EN
        check("model_out_last", {31'd0, bus.out_last}, {31'd0, q.size() == 1});
`endif
    endtask

    task automatic tick();
        bit rdy;
        @(posedge clk);
        if (!reset) begin
            q.delete();
            fresh = 1'b1;
        end else begin
            rdy = (q.size() == 0) || (q.size() == 1 && bus.out_ready);
            if (q.size() > 0 && bus.out_ready) void'(q.pop_front());
            if (bus.in_valid && rdy) begin
                for (int i = 0; i < N; i++) q.push_back(bus.A[i*W +: W]);
                fresh = 1'b0;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w1, w2, wd;
        w1 = 32'h44332211;
        w2 = 32'h88776655;
        wd = 32'hDEADBEEF;
        fresh = 1'b1;

        // basic drain
        add(1, w1, 1, 0, 1, 8'h00, 1, 0);
        add(0, 0, 1, 1, 1, 8'h11, 0, 0);
        add(0, 0, 1, 1, 1, 8'h22, 0, 0);
        add(0, 0, 1, 1, 1, 8'h33, 0, 0);
        add(0, 0, 1, 1, 1, 8'h44, 1, 1);
        add(0, 0, 1, 0, 0, 8'h00, 1, 0);
        // stall on first element, and on last element (in_ready follows out_ready)
        add(1, w1, 0, 0, 0, 8'h00, 1, 0);
        add(0, 0, 0, 1, 1, 8'h11, 0, 0);
        add(0, 0, 0, 1, 1, 8'h11, 0, 0);
        add(0, 0, 0, 1, 1, 8'h11, 0, 0);
        add(0, 0, 1, 1, 1, 8'h11, 0, 0);
        add(0, 0, 1, 1, 1, 8'h22, 0, 0);
        add(0, 0, 1, 1, 1, 8'h33, 0, 0);
        add(0, 0, 0, 1, 1, 8'h44, 0, 1);
        add(0, 0, 1, 1, 1, 8'h44, 1, 1);
        add(0, 0, 1, 0, 0, 8'h00, 1, 0);
        // back-to-back words, no gap
        add(1, w1, 1, 0, 0, 8'h00, 1, 0);
        add(1, w2, 1, 1, 1, 8'h11, 0, 0);
        add(1, w2, 1, 1, 1, 8'h22, 0, 0);
        add(1, w2, 1, 1, 1, 8'h33, 0, 0);
        add(1, w2, 1, 1, 1, 8'h44, 1, 1);
        add(0, 0, 1, 1, 1, 8'h55, 0, 0);
        add(0, 0, 1, 1, 1, 8'h66, 0, 0);
        add(0, 0, 1, 1, 1, 8'h77, 0, 0);
        add(0, 0, 1, 1, 1, 8'h88, 1, 1);
        add(0, 0, 1, 0, 0, 8'h00, 1, 0);
        // in_valid ignored while not ready
        add(1, w1, 1, 0, 0, 8'h00, 1, 0);
        add(0, 0, 1, 1, 1, 8'h11, 0, 0);
        add(1, wd, 1, 1, 1, 8'h22, 0, 0);
        add(1, wd, 1, 1, 1, 8'h33, 0, 0);
        add(1, wd, 1, 1, 1, 8'h44, 1, 1);
        add(0, 0, 1, 1, 1, 8'hEF, 0, 0);
        add(0, 0, 1, 1, 1, 8'hBE, 0, 0);
        add(0, 0, 1, 1, 1, 8'hAD, 0, 0);
        add(0, 0, 1, 1, 1, 8'hDE, 1, 1);
        add(0, 0, 1, 0, 0, 8'h00, 1, 0);

        // initial reset: DUT state unknown before the first reset edge
        drive(0, 0, 0, 0); tick();
        drive(0, 0, 0, 0); tick();

        foreach (tbl[i]) begin
            drive(1, tbl[i].a, tbl[i].iv, tbl[i].ordy);
            model_check();
            check($sformatf("vec%0d_out_valid", i), {31'd0, bus.out_valid}, {31'd0, tbl[i].ev});
            check($sformatf("vec%0d_in_ready", i), {31'd0, bus.in_ready}, {31'd0, tbl[i].erdy});
            if (tbl[i].chkb)
                check($sformatf("vec%0d_B", i), {24'd0, bus.B}, {24'd0, tbl[i].eb});
`ifdef PISO_LAST_EN
            check($sformatf("vec%0d_out_last", i), {31'd0, bus.out_last}, {31'd0, tbl[i].elast});
`endif
            tick();
        end

        // reset for 2 cycles mid-word, with handshakes asserted
        drive(1, w2, 1, 1); model_check(); tick();
        drive(1, 0, 0, 1);  model_check(); tick();
        drive(0, w1, 1, 1); model_check(); tick();
        drive(0, w1, 1, 1); model_check(); tick();
        drive(1, 0, 0, 0);
        model_check();
        check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_B", {24'd0, bus.B}, 32'd0);
        check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
`ifdef PISO_LAST_EN
        check("rst_out_last", {31'd0, bus.out_last}, 32'd0);
`endif
        tick();

        // randomized traffic against the reference model
        for (int c = 0; c < 600; c++) begin
            drive(logic'($urandom_range(0, 49) != 0), $urandom,
                  logic'($urandom_range(0, 1)), logic'($urandom_range(0, 3) != 0));
            model_check();
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
